// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core: FETCH, DECODE, EXECUTE and WRITE take one cycle each, so 4 cycles per instruction.
// There are no stalls or backpressure. Instruction memory is writable only while the core is idle or halted.
module multicycle_rv_core #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 8,
  parameter int RESULT_REG = 5,
  parameter int RESULT_W   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic                          IMEM_WE,
  input  logic [$clog2(IMEM_DEPTH)-1:0] IMEM_ADDR,
  input  logic [31:0]                   IMEM_WDATA,
  output logic [RESULT_W-1:0]           RESULT,
  output logic                          BUSY,
  output logic                          HALTED,
  output logic                          ILLEGAL,
  output logic [31:0]                   INSTRET
);
  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_B   = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_SYS = 7'h73;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITE, HALT} state_t;

  state_t          state;
  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] pc, rs1_val, rs2_val, imm, res, npc;
  logic [31:0]     ir, instret_cnt;
  logic            wr_q, ecall_q, bad_op_q, bad_pc_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_c;
  always_comb begin
    case (opcode)
      OP_LUI:  imm32 = {ir[31:12], 12'b0};
      OP_B:    imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:  imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
    imm_c = XLEN'($signed(imm32));
  end

  logic [XLEN-1:0] a, b, alu_y, nxt, sra_y;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq, take, wr_c, ecall_c, bad_c, pc_bad;

  assign a     = rs1_val;
  assign b     = (opcode == OP_R || opcode == OP_B) ? rs2_val : imm;
  assign shamt = b[4:0];
  assign sra_y = $signed(a) >>> shamt;
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  always_comb begin
    alu_y   = '0;
    nxt     = pc + XLEN'(4);
    take    = 1'b0;
    wr_c    = 1'b0;
    ecall_c = 1'b0;
    bad_c   = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        wr_c = 1'b1;
        case (funct3)
          3'd0:    alu_y = (opcode == OP_R && funct7[5]) ? a - b : a + b;
          3'd1:    alu_y = a << shamt;
          3'd2:    alu_y = {{(XLEN-1){1'b0}}, lt_s};
          3'd3:    alu_y = {{(XLEN-1){1'b0}}, lt_u};
          3'd4:    alu_y = a ^ b;
          3'd5:    alu_y = funct7[5] ? sra_y : a >> shamt;
          3'd6:    alu_y = a | b;
          default: alu_y = a & b;
        endcase
        // funct7 only qualifies R-type ops and the immediate shifts
        if (opcode == OP_R)
          bad_c = !(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
        else if (funct3 == 3'd1)
          bad_c = funct7 != 7'h00;
        else if (funct3 == 3'd5)
          bad_c = !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OP_LUI: begin
        wr_c  = 1'b1;
        alu_y = imm;
      end
      OP_JAL: begin
        wr_c  = 1'b1;
        alu_y = pc + XLEN'(4);
        nxt   = pc + imm;
      end
      OP_B: begin
        case (funct3)
          3'd0:    take = eq;
          3'd1:    take = !eq;
          3'd4:    take = lt_s;
          3'd5:    take = !lt_s;
          3'd6:    take = lt_u;
          3'd7:    take = !lt_u;
          default: bad_c = 1'b1;
        endcase
        if (take) nxt = pc + imm;
      end
      OP_SYS: begin
        if (ir == 32'h0000_0073) ecall_c = 1'b1;
        else                     bad_c   = 1'b1;
      end
      default: bad_c = 1'b1;
    endcase
    pc_bad = (|nxt[1:0]) || (|nxt[XLEN-1:AW+2]);
  end

  always_ff @(posedge CLK) begin
    if (IMEM_WE && !BUSY) imem[IMEM_ADDR] <= IMEM_WDATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      imm         <= '0;
      res         <= '0;
      npc         <= '0;
      wr_q        <= 1'b0;
      ecall_q     <= 1'b0;
      bad_op_q    <= 1'b0;
      bad_pc_q    <= 1'b0;
      instret_cnt <= '0;
      BUSY        <= 1'b0;
      HALTED      <= 1'b0;
      ILLEGAL     <= 1'b0;
      RESULT      <= '0;
      INSTRET     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      RESULT  <= regs[RESULT_REG][RESULT_W-1:0];
      INSTRET <= instret_cnt;
      case (state)
        IDLE, HALT: begin
          if (START) begin
            state       <= FETCH;
            pc          <= '0;
            ILLEGAL     <= 1'b0;
            instret_cnt <= '0;
            BUSY        <= 1'b1;
            HALTED      <= 1'b0;
          end
        end
        FETCH: begin
          ir    <= imem[pc[AW+1:2]];
          state <= DECODE;
        end
        DECODE: begin
          rs1_val <= regs[ir[19:15]];
          rs2_val <= regs[ir[24:20]];
          imm     <= imm_c;
          state   <= EXECUTE;
        end
        EXECUTE: begin
          res      <= alu_y;
          npc      <= nxt;
          wr_q     <= wr_c;
          ecall_q  <= ecall_c;
          bad_op_q <= bad_c;
          bad_pc_q <= pc_bad;
          state    <= WRITE;
        end
        WRITE: begin
          if (bad_op_q) begin
            state   <= HALT;
            BUSY    <= 1'b0;
            HALTED  <= 1'b1;
            ILLEGAL <= 1'b1;
          end else begin
            if (wr_q && rd != 5'd0) regs[rd] <= res;
            pc          <= npc;
            instret_cnt <= instret_cnt + 32'd1;
            // ECALL takes priority: it halts cleanly even if pc+4 runs off the end
            if (ecall_q || bad_pc_q) begin
              state   <= HALT;
              BUSY    <= 1'b0;
              HALTED  <= 1'b1;
              ILLEGAL <= !ecall_q;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_rv_core.sv
// Directed-vector bench for multicycle_rv_core: small programs with hand-computed results.
module tb_multicycle_rv_core;
  localparam int DEPTH = 16;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, start, imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] result;
  logic [31:0] result_w, instret, instret_w;
  logic        busy, halted, illegal, busy_w, halted_w, illegal_w;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;
  logic [31:0] prog [$];

  typedef struct {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t alu_tab [$];

  typedef struct {
    int          f3;
    logic [31:0] exp;
  } br_vec_t;
  br_vec_t br_tab [$];

  always #5 clk = ~clk;

  multicycle_rv_core #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESULT_REG(5), .RESULT_W(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .IMEM_WE(imem_we), .IMEM_ADDR(imem_addr),
    .IMEM_WDATA(imem_wdata), .RESULT(result), .BUSY(busy), .HALTED(halted),
    .ILLEGAL(illegal), .INSTRET(instret)
  );

  multicycle_rv_core #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESULT_REG(5), .RESULT_W(32)) dut_w (
    .CLK(clk), .RST(rst), .START(start), .IMEM_WE(imem_we), .IMEM_ADDR(imem_addr),
    .IMEM_WDATA(imem_wdata), .RESULT(result_w), .BUSY(busy_w), .HALTED(halted_w),
    .ILLEGAL(illegal_w), .INSTRET(instret_w)
  );

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
  endfunction

  function automatic logic [31:0] enc_lui(input int imm20, input int rd);
    return {imm20[19:0], rd[4:0], 7'h37};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // unused words become opcode 0, which the core rejects
  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      imem_we    = 1'b1;
      imem_addr  = i[3:0];
      imem_wdata = (i < prog.size()) ? prog[i] : 32'h0;
    end
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  task automatic run(input bit disturb, input bit co_we, input logic [31:0] co_dat, output int cycles);
    @(posedge clk); #1;
    start      = 1'b1;
    imem_we    = co_we;
    imem_addr  = '0;
    imem_wdata = co_dat;
    @(posedge clk); #1;
    start   = 1'b0;
    imem_we = 1'b0;
    cycles  = 0;
    while (cycles < 1000) begin
      @(negedge clk);
      if (cycles == 0) check("busy_after_start", 32'(busy), 1);
      if (halted) break;
      @(posedge clk); #1;
      cycles++;
      start      = disturb && (cycles == 6);
      imem_we    = start;
      imem_wdata = enc_i(22, 0, 0, 5);
    end
    check("halted", 32'(halted), 1);
    check("busy_in_halt", 32'(busy), 0);
    check("halted_w", 32'(halted_w), 1);
    check("busy_w_in_halt", 32'(busy_w), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_result", 32'(result), 0);
    check("rst_instret", instret, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_result", 32'(result), 0);

    // running sum: x3 = 1 + 6*2 = 13, x5 = 15
    prog = '{enc_i(2, 0, 0, 2), enc_i(1, 0, 0, 3)};
    for (int i = 0; i < 6; i++) prog.push_back(enc_r(0, 2, 3, 0, 3));
    prog.push_back(enc_r(0, 2, 3, 0, 5));
    prog.push_back(ECALL);
    load_prog();
    run(0, 0, 0, cyc);
    check("sum_cycles", cyc, 40);
    check("sum_illegal", 32'(illegal), 0);
    check("sum_result", 32'(result), 32'h000F);
    check("sum_instret", instret, 10);
    check("sum_instret_w", instret_w, 10);
    check("sum_illegal_w", 32'(illegal_w), 0);

    // x1 = 0xFFFFFFF0, x2 = 21; zero-result rows follow a non-zero row
    alu_tab.push_back('{enc_i('h404, 1, 5, 5), NOP, 32'hFFFF_FFFF});
    alu_tab.push_back('{enc_i(4, 1, 5, 5), NOP, 32'h0FFF_FFFF});
    alu_tab.push_back('{enc_r(0, 1, 0, 3, 5), NOP, 32'h0000_0001});
    alu_tab.push_back('{enc_r(0, 1, 0, 2, 5), NOP, 32'h0000_0000});
    alu_tab.push_back('{enc_r(0, 1, 1, 0, 5), NOP, 32'hFFFF_FFE0});
    alu_tab.push_back('{enc_r('h20, 1, 2, 0, 5), NOP, 32'h0000_0025});
    alu_tab.push_back('{enc_r(0, 2, 1, 1, 5), NOP, 32'hFE00_0000});
    alu_tab.push_back('{enc_r(0, 2, 1, 5, 5), NOP, 32'h0000_07FF});
    alu_tab.push_back('{enc_r('h20, 2, 1, 5, 5), NOP, 32'hFFFF_FFFF});
    alu_tab.push_back('{enc_r(0, 2, 1, 4, 5), NOP, 32'hFFFF_FFE5});
    alu_tab.push_back('{enc_r(0, 2, 1, 6, 5), NOP, 32'hFFFF_FFF5});
    alu_tab.push_back('{enc_r(0, 2, 1, 7, 5), NOP, 32'h0000_0010});
    alu_tab.push_back('{enc_i(5, 1, 3, 5), NOP, 32'h0000_0000});
    alu_tab.push_back('{enc_i(-15, 1, 2, 5), NOP, 32'h0000_0001});
    alu_tab.push_back('{enc_i('h0FF, 1, 4, 5), NOP, 32'hFFFF_FF0F});
    alu_tab.push_back('{enc_i('h100, 2, 6, 5), NOP, 32'h0000_0115});
    alu_tab.push_back('{enc_i('h0FF, 1, 7, 5), NOP, 32'h0000_00F0});
    alu_tab.push_back('{enc_i(4, 1, 1, 5), NOP, 32'hFFFF_FF00});
    alu_tab.push_back('{enc_i('h7FF, 1, 0, 5), NOP, 32'h0000_07EF});
    alu_tab.push_back('{enc_lui('hABCDE, 5), NOP, 32'hABCD_E000});
    alu_tab.push_back('{enc_i(5, 0, 0, 0), enc_r(0, 0, 0, 0, 5), 32'h0000_0000});
    foreach (alu_tab[i]) begin
      prog = '{enc_i(-16, 0, 0, 1), enc_i(21, 0, 0, 2), alu_tab[i].op_a, alu_tab[i].op_b, ECALL};
      load_prog();
      run(0, 0, 0, cyc);
      check($sformatf("alu%0d_r16", i), 32'(result), 32'(alu_tab[i].exp[15:0]));
      check($sformatf("alu%0d_r32", i), result_w, alu_tab[i].exp);
    end

    // count x5 up to 5 with a BNE back-edge: 2 + 5*2 + 1 instructions
    prog = '{enc_i(0, 0, 0, 5), enc_i(5, 0, 0, 6), enc_i(1, 5, 0, 5), enc_b(-4, 6, 5, 1), ECALL};
    load_prog();
    run(0, 0, 0, cyc);
    check("loop_result", 32'(result), 5);
    check("loop_instret", instret, 13);
    check("loop_cycles", cyc, 52);

    // x1=-16 vs x2=21: taken skips the +1, giving x5=2 over 6 instructions
    br_tab.push_back('{0, 32'd3});
    br_tab.push_back('{1, 32'd2});
    br_tab.push_back('{4, 32'd2});
    br_tab.push_back('{5, 32'd3});
    br_tab.push_back('{6, 32'd3});
    br_tab.push_back('{7, 32'd2});
    foreach (br_tab[i]) begin
      prog = '{enc_i(-16, 0, 0, 1), enc_i(21, 0, 0, 2), enc_i(0, 0, 0, 5),
               enc_b(8, 2, 1, br_tab[i].f3), enc_i(1, 5, 0, 5), enc_i(2, 5, 0, 5), ECALL};
      load_prog();
      run(0, 0, 0, cyc);
      check($sformatf("br%0d_result", i), 32'(result), br_tab[i].exp);
      check($sformatf("br%0d_instret", i), instret, (br_tab[i].exp == 2) ? 6 : 7);
      check($sformatf("br%0d_cycles", i), cyc, (br_tab[i].exp == 2) ? 24 : 28);
    end

    // opcode 0x7F with rd=x5, then an R-type with an unsupported funct7
    for (int k = 0; k < 2; k++) begin
      prog = '{enc_i(3, 0, 0, 5), enc_i(4, 5, 0, 5),
               (k == 0) ? 32'h0000_02FF : enc_r('h20, 1, 1, 1, 5), enc_i(99, 0, 0, 5), ECALL};
      load_prog();
      run(0, 0, 0, cyc);
      check($sformatf("ill%0d_illegal", k), 32'(illegal), 1);
      check($sformatf("ill%0d_instret", k), instret, 2);
      check($sformatf("ill%0d_result", k), 32'(result), 7);
      check($sformatf("ill%0d_cycles", k), cyc, 12);
    end

    // JAL from pc 4 to 64 = end of memory: link written, retires, flagged
    prog = '{NOP, enc_j(60, 5), ECALL};
    load_prog();
    run(0, 0, 0, cyc);
    check("jal_oor_illegal", 32'(illegal), 1);
    check("jal_oor_link", 32'(result), 8);
    check("jal_oor_instret", instret, 2);

    prog = '{enc_j(2, 5), ECALL};
    load_prog();
    run(0, 0, 0, cyc);
    check("jal_mis_illegal", 32'(illegal), 1);
    check("jal_mis_link", 32'(result), 4);
    check("jal_mis_instret", instret, 1);

    // IMEM write and START attempted mid-run must both be ignored
    prog = '{enc_i(11, 0, 0, 5), NOP, NOP, NOP, ECALL};
    load_prog();
    run(1, 0, 0, cyc);
    check("busy_start_cycles", cyc, 20);
    check("busy_start_result", 32'(result), 11);
    check("busy_start_illegal", 32'(illegal), 0);
    run(0, 0, 0, cyc);
    check("busy_we_result", 32'(result), 11);
    check("busy_we_instret", instret, 5);

    // reset during the second instruction's EXECUTE
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("pre_rst_result", 32'(result), 11);
    check("pre_rst_instret", instret, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_result", 32'(result), 0);
    check("arst_instret", instret, 0);
    check("arst_halted", 32'(halted), 0);
    @(posedge clk); #1 rst = 1'b0;
    run(0, 1, enc_i(33, 0, 0, 5), cyc);
    check("rerun_result", 32'(result), 33);
    check("rerun_instret", instret, 5);
    check("rerun_cycles", cyc, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_rv_core.md
# multicycle_rv_core

Parametrised multi-cycle RV32I-subset core. Each instruction passes through four sequential states: fetch, decode, execute and write-back. The core adds a loadable instruction memory, R/I-type ALU ops, LUI, conditional branches, JAL, a halt/illegal mechanism, a retired-instruction counter and an exported result register. It is the standalone top-level compute core of the design and is driven by a testbench or a host that loads the program and pulses START.

## Interface
- XLEN, 32: datapath and register width.
- IMEM_DEPTH, 8: instruction memory words; power of two, ≥2.
- RESULT_REG, 5: architectural register mirrored on RESULT.
- RESULT_W, 16: RESULT width, ≤ XLEN.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins execution at PC 0.
- IMEM_WE  in  1  instruction memory write enable.
- IMEM_ADDR  in  $clog2(IMEM_DEPTH)  word address for the write.
- IMEM_WDATA  in  32  instruction word to write.
- RESULT  out  RESULT_W  registered copy of x[RESULT_REG][RESULT_W-1:0].
- BUSY  out  1  high in FETCH/DECODE/EXECUTE/WRITE.
- HALTED  out  1  high in HALT.
- ILLEGAL  out  1  high in HALT when the halt cause is an illegal condition.
- INSTRET  out  32  count of retired instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITE, HALT.
- Transitions: IDLE/HALT –START→ FETCH → DECODE → EXECUTE → WRITE → FETCH, or WRITE → HALT on a halt cause.
- On START: PC←0, ILLEGAL←0, INSTRET←0. Register contents are preserved.
- PC is a byte address. FETCH reads imem[PC[$clog2(IMEM_DEPTH)+1:2]] into the instruction register.
- DECODE latches rs1/rs2 values and the sign-extended immediate.
- EXECUTE computes the ALU result and the next PC.
- WRITE does three things:
  - writes rd when the op writes and rd≠0;
  - updates PC;
  - increments INSTRET, including on ECALL.
- Supported ops:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI; JAL, where rd←PC+4; BEQ, BNE, BLT, BGE, BLTU, BGEU; ECALL, which is a normal halt.
- Arithmetic rules:
  - XLEN-bit wrap-around; carries are discarded.
  - Shift amount is the low 5 bits.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Branch and JAL targets are PC + the sign-extended immediate.
- x0 reads as zero. Writes to x0 are dropped.
- Halt causes, evaluated in EXECUTE and taking effect at WRITE → HALT:
  - ECALL: ILLEGAL=0, instruction retires.
  - Unsupported opcode/funct: ILLEGAL=1, no register write, no retire.
  - Next PC not 4-aligned, or next PC ≥ 4·IMEM_DEPTH: ILLEGAL=1. The instruction retires and its rd write still occurs. PC holds the offending value.
- IMEM writes:
  - Accepted only in IDLE or HALT; ignored while BUSY.
  - An IMEM write coincident with START is performed first, so it is visible to the first fetch.
- START while BUSY is ignored.

## Timing
- Reset values: state=IDLE, PC=0, all registers 0, RESULT=0, BUSY=0, HALTED=0, ILLEGAL=0, INSTRET=0. Instruction memory is not reset.
- Reset asserted mid-instruction aborts immediately. No partial write occurs.
- START sampled in cycle N → FETCH in N+1 → BUSY=1 from N+1.
- Each instruction takes exactly 4 cycles, so the k-th instruction's write lands at the end of cycle N+4k.
- RESULT and INSTRET update one cycle after the WRITE edge, i.e. they are registered from architectural state.
- The halting instruction's WRITE edge enters HALT. HALTED/ILLEGAL are valid that cycle and BUSY drops in the same cycle.
- Taken and not-taken branches have identical latency. There are no stalls.

## Test plan
- Reset then load:
  - Program: ADDI x2,x0,2; ADDI x3,x0,1; six × ADD x3,x3,x2; ADD x5,x3,x2; ECALL, with IMEM_DEPTH=16.
  - START → HALTED=1 and ILLEGAL=0 after 40 cycles; RESULT=0x000F; INSTRET=10.
- ALU sweep: x1=0xFFFFFFF0 via LUI/ADDI.
  - SRAI x5,x1,4 → RESULT=0xFFFF; SRLI → 0xFFFF, with the upper bits checked via RESULT_W=32 config = 0x0FFFFFFF.
  - SLTU x5,x0,x1 → 1; SLT x5,x0,x1 → 0.
  - ADD x5,x1,x1 wrap → 0xFFE0.
- Branch loop: count x5 from 0 to 5 with BNE back-edge, then ECALL.
  - RESULT=5; INSTRET equals the instruction count; every instruction spans exactly 4 cycles.
- Illegal opcode 0x0000007F at word 2 → HALTED=1, ILLEGAL=1, INSTRET=2, rd unchanged.
- JAL with target 4·IMEM_DEPTH → ILLEGAL=1 and link register written. A further JAL offset of +2 → ILLEGAL=1 (misaligned).
- Robustness:
  - IMEM_WE while BUSY leaves the program unchanged.
  - START while BUSY is ignored.
  - RST pulsed mid-EXECUTE clears all outputs asynchronously; a subsequent START re-runs correctly.
  - Writes to x0 read back as 0.
